// File: rtl/addsub_norm_fpu.sv
// addsub_norm_fpu
//   FP16 add/subtract + normalize stage, fed by the compare-and-shift
//   alignment stage. Takes two exponent-aligned 11-bit mantissas (hidden bit
//   explicit) plus the larger exponent. It does a signed-magnitude add or
//   subtract, then normalizes left one bit per cycle. The result is packed
//   into an IEEE half word with truncation rounding.
//
// Ports
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake (ready only when idle)
//   op_sub              0: A+B, 1: A-B
//   sign_a, sign_b      operand signs
//   exp_max[4:0]        larger exponent (0 treated as 1)
//   al_man_a/b[10:0]    aligned mantissas
//   out_valid/out_ready result handshake (valid held until accepted)
//   result[15:0]        {sign, exp, frac}
//   overflow            result saturated to infinity
//   zero                result is exactly zero
module addsub_norm_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [4:0]  exp_max,
  input  logic [10:0] al_man_a,
  input  logic [10:0] al_man_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_NORM, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] ma_q, ma_d, mb_q, mb_d;
  logic        sa_q, sa_d, sb_q, sb_d, sub_q, sub_d;
  logic [4:0]  exp_q, exp_d;
  logic [10:0] man_q, man_d;
  logic        sgn_q, sgn_d;
  logic        wz_q, wz_d;       // working result is zero
  logic [15:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  // ADD-cycle datapath
  logic        eff_sub, a_ge_b;
  logic [11:0] sum;
  logic [10:0] diff;
  logic [10:0] add_man;
  logic [5:0]  add_exp;
  logic        add_sgn, add_zero, add_ovf;

  always_comb begin
    eff_sub = sa_q ^ sb_q ^ sub_q;
    sum     = {1'b0, ma_q} + {1'b0, mb_q};
    a_ge_b  = (ma_q >= mb_q);
    diff    = a_ge_b ? (ma_q - mb_q) : (mb_q - ma_q);
    if (!eff_sub) begin
      // carry out: drop the LSB (truncate) and bump the exponent
      add_man = sum[11] ? sum[11:1] : sum[10:0];
      add_exp = {1'b0, exp_q} + {5'd0, sum[11]};
      add_sgn = sa_q;
    end else begin
      add_man = diff;
      add_exp = {1'b0, exp_q};
      add_sgn = a_ge_b ? sa_q : (sb_q ^ sub_q);
    end
    add_zero = (add_man == 11'd0);
    add_ovf  = !add_zero && (add_exp >= 6'd31);
  end

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    man_d   = man_q;
    sgn_d   = sgn_q;
    wz_d    = wz_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ma_d    = al_man_a;
          mb_d    = al_man_b;
          sa_d    = sign_a;
          sb_d    = sign_b;
          sub_d   = op_sub;
          exp_d   = (exp_max == 5'd0) ? 5'd1 : exp_max;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (add_ovf) begin
          res_d   = {add_sgn, 5'h1f, 10'h000};
          ovf_d   = 1'b1;
          zero_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          man_d   = add_man;
          exp_d   = add_exp[4:0];
          sgn_d   = add_zero ? 1'b0 : add_sgn;
          wz_d    = add_zero;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (wz_q || man_q[10] || (exp_q == 5'd1)) begin
          // exp stuck at 1 without hidden bit -> denormal, exp field 0
          if (wz_q) res_d = 16'h0000;
          else      res_d = {sgn_q, (man_q[10] ? exp_q : 5'd0), man_q[9:0]};
          ovf_d   = 1'b0;
          zero_d  = wz_q;
          state_d = S_DONE;
        end else begin
          man_d = {man_q[9:0], 1'b0};
          exp_d = exp_q - 5'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      sgn_q   <= 1'b0;
      wz_q    <= 1'b0;
      res_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      sgn_q   <= sgn_d;
      wz_q    <= wz_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_norm_fpu.sv
module tb_addsub_norm_fpu;

  logic        clk, rst;
  logic        in_valid, in_ready, op_sub, sign_a, sign_b;
  logic [4:0]  exp_max;
  logic [10:0] al_man_a, al_man_b;
  logic        out_valid, out_ready, overflow, zero;
  logic [15:0] result;

  addsub_norm_fpu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .sign_a(sign_a), .sign_b(sign_b),
    .exp_max(exp_max), .al_man_a(al_man_a), .al_man_b(al_man_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        zr;
    int          lat;
    int          acc;
  } exp_t;

  // Reference: signed integer arithmetic on the mantissas, then normalize.
  function automatic exp_t model(input bit sa, input bit sb, input bit sub,
                                 input int e_in, input int a, input int b);
    exp_t r;
    int va, vb, s, mag, e, n;
    bit sg;
    va  = sa ? -a : a;
    vb  = (sb ^ sub) ? -b : b;
    s   = va + vb;
    sg  = (s < 0);
    mag = sg ? -s : s;
    e   = (e_in == 0) ? 1 : e_in;
    n   = 0;
    r.acc = 0;
    if (mag == 0) begin
      r.res = 16'h0000; r.ovf = 1'b0; r.zr = 1'b1; r.lat = 3;
      return r;
    end
    if (mag >= 2048) begin mag = mag / 2; e = e + 1; end
    if (e >= 31) begin
      r.res = {sg, 5'h1f, 10'h000}; r.ovf = 1'b1; r.zr = 1'b0; r.lat = 2;
      return r;
    end
    while (mag < 1024 && e > 1) begin mag = mag * 2; e = e - 1; n++; end
    r.res = {sg, (mag >= 1024) ? 5'(e) : 5'd0, 10'(mag % 1024)};
    r.ovf = 1'b0; r.zr = 1'b0; r.lat = 3 + n;
    return r;
  endfunction

  // Compare process: every cycle, handshake and outputs versus the model.
  exp_t q[$];
  int   cyc = 0;

  always @(negedge clk) begin
    exp_t m;
    if (rst) begin
      q.delete();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
    end else begin
      chk("in_ready", in_ready, q.size() == 0);
      if (q.size() > 0) begin
        chk("out_valid", out_valid, (cyc - q[0].acc) >= q[0].lat);
        if (out_valid) begin
          chk("result", result, q[0].res);
          chk("overflow", overflow, q[0].ovf);
          chk("zero", zero, q[0].zr);
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("spurious_valid", out_valid, 1'b0);
      end
      if (in_valid && in_ready) begin
        m = model(sign_a, sign_b, op_sub, int'(exp_max), int'(al_man_a), int'(al_man_b));
        m.acc = cyc;
        q.push_back(m);
      end
    end
    cyc++;
  end

  task automatic do_op(input bit sa, input bit sb, input bit sub, input logic [4:0] e,
                       input logic [10:0] a, input logic [10:0] b,
                       input int hold, input bit pre_rdy,
                       input bit lit, input logic [15:0] lit_res, input int lit_lat);
    int n;
    bit got;
    exp_t m;
    if (lit) begin
      m = model(sa, sb, sub, int'(e), int'(a), int'(b));
      chk("model_res", m.res, lit_res);
      chk("model_lat", m.lat, lit_lat);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; sign_a = sa; sign_b = sb; op_sub = sub;
    exp_max = e; al_man_a = a; al_man_b = b;
    out_ready = pre_rdy;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin chk("accept_timeout", 0, 1); in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin got = 1'b1; break; end
    end
    if (!got) begin chk("valid_timeout", 0, 1); out_ready = 1'b0; return; end
    if (lit) begin
      chk("lit_result", result, lit_res);
      chk("lit_latency", n, lit_lat);
    end
    if (!pre_rdy) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        al_man_a = 11'($urandom); al_man_b = 11'($urandom);
        exp_max = 5'($urandom); op_sub = 1'($urandom);
      end
      if (lit && hold > 0) begin
        @(negedge clk);
        chk("lit_held", result, lit_res);
        chk("lit_busy_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int rises;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    sign_a = 1'b0; sign_b = 1'b0; exp_max = '0; al_man_a = '0; al_man_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, 16'h0000);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_zero", zero, 1'b0);

    do_op(0, 0, 0, 5'd15, 11'h400, 11'h400, 0, 0, 1, 16'h4000, 3);
    do_op(0, 0, 1, 5'd15, 11'h400, 11'h200, 0, 0, 1, 16'h3800, 4);
    do_op(0, 0, 1, 5'd20, 11'h5A5, 11'h5A5, 0, 0, 1, 16'h0000, 3);
    do_op(0, 1, 0, 5'd20, 11'h5A5, 11'h5A5, 0, 1, 1, 16'h0000, 3);
    do_op(1, 1, 0, 5'd30, 11'h7FF, 11'h7FF, 0, 0, 1, 16'hFC00, 2);
    do_op(0, 0, 1, 5'd3,  11'h401, 11'h400, 5, 0, 1, 16'h0004, 5);
    do_op(0, 0, 1, 5'd0,  11'h100, 11'h300, 0, 0, 1, 16'h8200, 3);

    // abort during normalization
    @(posedge clk); #1;
    in_valid = 1'b1; sign_a = 0; sign_b = 0; op_sub = 1;
    exp_max = 5'd20; al_man_a = 11'h401; al_man_b = 11'h400;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rises = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    chk("abort_no_output", rises, 0);
    do_op(0, 0, 0, 5'd15, 11'h400, 11'h400, 0, 0, 1, 16'h4000, 3);

    for (int k = 0; k < 250; k++) begin
      logic [10:0] a, b;
      logic [4:0]  e;
      int mode;
      mode = $urandom_range(0, 3);
      a = 11'($urandom) | 11'h400;
      case (mode)
        0: begin a = 11'($urandom); b = 11'($urandom); end
        1: b = a >> $urandom_range(0, 10);
        2: b = a - 11'($urandom_range(0, 3));
        default: begin a = 11'($urandom_range(0, 15)); b = 11'($urandom_range(0, 15)); end
      endcase
      if ($urandom_range(0, 1) == 1) begin logic [10:0] t; t = a; a = b; b = t; end
      e = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(1, 30));
      do_op(1'($urandom), 1'($urandom), 1'($urandom), e, a, b,
            $urandom_range(0, 3), 1'($urandom), 0, 16'h0000, 0);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/addsub_norm_fpu.md
# addsub_norm_fpu

Multi-cycle FP16 add/subtract and normalize stage that sits directly downstream of the FPU compare-and-shift alignment stage. It consumes two exponent-aligned 11-bit mantissas (hidden bit explicit) plus the larger exponent. It then performs the signed magnitude add or subtract and normalizes the result with a one-bit-per-cycle shifter. Finally it packs an IEEE-754 half-precision word, using a valid/ready handshake on both sides.

## Interface
- No parameters. Widths are fixed to FP16: 5-bit exponent, 11-bit mantissa including the hidden bit.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- op_sub  in  1  0 = A+B, 1 = A−B.
- sign_a, sign_b  in  1 each  operand signs.
- exp_max  in  5  larger operand exponent; value 0 is treated as 1 (denormal inputs).
- al_man_a, al_man_b  in  11 each  aligned mantissas.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- result  out  16  packed FP16 word {sign, exp[4:0], frac[9:0]}.
- overflow  out  1  result saturated to infinity.
- zero  out  1  result is exactly zero.

## Operation
- States: IDLE, ADD, NORM, DONE. Encoding is free.
- IDLE: in_ready=1. On in_valid&&in_ready, register all inputs and go to ADD.
- ADD (one cycle):
  - Effective subtract: eff_sub = sign_a ^ sign_b ^ op_sub.
  - Add path (eff_sub=0): 12-bit sum = man_a+man_b, sign = sign_a.
    - If sum[11]=1: mantissa = sum>>1 (LSB discarded, truncation), exp = exp_max+1.
  - Subtract path (eff_sub=1):
    - If man_a>=man_b: mantissa = man_a−man_b, sign = sign_a.
    - Otherwise: mantissa = man_b−man_a, sign = sign_b^op_sub.
  - Zero result: equal mantissas, or both mantissas 0. Force sign=0 and zero=1.
  - Overflow: exp reaches 31. Set result to sign,11111,0000000000 (infinity) and overflow=1. Skip NORM and go to DONE.
  - Otherwise go to NORM.
- NORM (one edge per step):
  - Go to DONE when any of these holds: zero result, mantissa[10]=1, or exp==1.
  - Otherwise shift the mantissa left by 1 and decrement exp.
  - At most 10 shift steps.
- Pack, on the transition to DONE:
  - Normal: mantissa[10]=1 → exp field = exp.
  - Denormal: mantissa[10]=0 with exp==1 → exp field = 0.
  - frac = mantissa[9:0].
  - Zero result packs 0x0000.
- DONE: out_valid=1. Hold result, overflow and zero stable. Go to IDLE on out_ready. A new operand cannot be accepted in the same cycle, because in_ready=0 in DONE.
- Rounding is truncation only.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=16'h0000, overflow=0, zero=0.
- Reset asserted mid-operation (ADD, NORM or DONE) aborts immediately with no output. State returns to IDLE.
- Latency from the accept edge to the first cycle with out_valid=1 is 3 edges plus N, where N = number of normalize shifts (0–10).
  - Minimum 3 edges.
  - Maximum 13 edges.
  - Overflow case: 2 edges, since NORM is skipped.
- Throughput: one operation per latency+1 cycles at minimum. There is no overlap between operations.
- out_valid with out_ready both high on the same edge retires the result. out_valid is 0 in the next cycle.
- out_ready held high before DONE has no effect.
- in_valid while busy is ignored. The upstream stage must hold its operands until it sees in_ready.

## Test plan
- 1.0+1.0: exp_max=15, a=b=0x400, op_sub=0 → result 0x4000, overflow=0, zero=0, out_valid 3 edges after accept.
- 1.0−0.5 pre-aligned: exp_max=15, a=0x400, b=0x200, op_sub=1 → one shift, result 0x3800, out_valid 4 edges after accept.
- Cancellation: exp_max=20, a=b=0x5A5, sign_a=sign_b=0, op_sub=1 → result 0x0000, zero=1; same operands with sign_b=1, op_sub=0 → same result.
- Overflow: exp_max=30, a=b=0x7FF, op_sub=0, sign_a=sign_b=1 → result 0xFC00, overflow=1, out_valid 2 edges after accept.
- Denormal and backpressure:
  - Input: exp_max=3, a=0x401, b=0x400, op_sub=1 → diff 0x001, exp stops at 1, result 0x0004.
  - Hold out_ready=0 for 5 cycles → result stable, in_ready=0, new in_valid ignored.
- Reset mid-NORM: operands needing a 10-shift normalize (exp_max=20, a=0x401, b=0x400, op_sub=1); assert rst on the 3rd NORM cycle → out_valid never rises, in_ready=1 immediately, next operation 1.0+1.0 completes correctly (0x4000).
